// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 codes, FSM states,
// access-size and legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_t;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    logic [2:0] n;
    case (f3)
      F3_B, F3_BU: n = 3'd1;
      F3_H, F3_HU: n = 3'd2;
      F3_W:        n = 3'd4;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic legal(input logic st, input logic [2:0] f3);
    logic ok;
    if (st) ok = f3 inside {F3_B, F3_H, F3_W};
    else    ok = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data shifting and
// load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [7:0]  st_mask,
  output logic [63:0] st_wide,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] ld_data
);

  logic [7:0]  base;
  logic [63:0] shifted;
  logic [31:0] sh;

  always_comb begin
    base = 8'h00;
    unique case (1'b1)
      st_size == 3'd1: base = 8'h01;
      st_size == 3'd2: base = 8'h03;
      st_size == 3'd4: base = 8'h0f;
      default: ;
    endcase
    st_mask = base << st_off;
    shifted = {32'h0, st_wdata} << {st_off, 3'b000};
    // disabled lanes carry zero, not stray data
    st_wide = '0;
    for (int i = 0; i < 8; i++) begin
      if (st_mask[i]) st_wide[8*i +: 8] = shifted[8*i +: 8];
    end
  end

  always_comb begin
    sh = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:  ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:  ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_W:  ld_data = sh;
      F3_BU: ld_data = {24'h0, sh[7:0]};
      F3_HU: ld_data = {16'h0, sh[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store unit: drives the word-addressed data
// memory, splitting word-crossing accesses in two.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_addr,
  output logic [31:0] data_write,
  output logic [3:0]  data_write_byte,
  output logic        data_read_valid,
  output logic        data_write_valid,
  input  logic [31:0] data_read
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic        st_q, err_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  mask_q;
  logic [63:0] wide_q;
  logic [31:0] lo_q, hi_q, lo_n, hi_n;

  logic        accept, latch;
  logic [7:0]  mask_in;
  logic [63:0] wide_in;
  logic [31:0] ld_data;

  logic        rd_n, wr_n;
  logic [31:0] addr_n, wd_n;
  logic [3:0]  be_n;

  lsu_align u_align (
    .st_off    (req_addr[1:0]),
    .st_size   (size_of(req_funct3)),
    .st_wdata  (req_wdata),
    .st_mask   (mask_in),
    .st_wide   (wide_in),
    .ld_lo     (lo_q),
    .ld_hi     (hi_q),
    .ld_off    (off_q),
    .ld_funct3 (f3_q),
    .ld_data   (ld_data)
  );

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !st_q) ? ld_data : 32'h0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = data_addr;
    be_n    = 4'h0;
    wd_n    = 32'h0;
    lo_n    = lo_q;
    hi_n    = hi_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          latch = 1'b1;
          cnt_n = '0;
          lo_n  = 32'h0;
          hi_n  = 32'h0;
          if (!legal(req_is_store, req_funct3)) begin
            state_n = RESP;
          end else begin
            state_n = ACC0;
            addr_n  = {req_addr[31:2], 2'b00};
            if (req_is_store) begin
              wr_n = 1'b1;
              be_n = mask_in[3:0];
              wd_n = wide_in[31:0];
            end else begin
              rd_n = 1'b1;
            end
          end
        end
      end
      ACC0: begin
        if (cnt == CNT_LAST) begin
          lo_n  = data_read;
          cnt_n = '0;
          if (mask_q[7:4] != 4'h0) begin
            state_n = ACC1;
            addr_n  = data_addr + 32'd4;
            if (st_q) begin
              wr_n = 1'b1;
              be_n = mask_q[7:4];
              wd_n = wide_q[63:32];
            end else begin
              rd_n = 1'b1;
            end
          end else begin
            state_n = RESP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
          rd_n  = data_read_valid;
          wr_n  = data_write_valid;
          be_n  = data_write_byte;
          wd_n  = data_write;
        end
      end
      ACC1: begin
        if (cnt == CNT_LAST) begin
          hi_n    = data_read;
          cnt_n   = '0;
          state_n = RESP;
        end else begin
          cnt_n = cnt + CW'(1);
          rd_n  = data_read_valid;
          wr_n  = data_write_valid;
          be_n  = data_write_byte;
          wd_n  = data_write;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      st_q             <= 1'b0;
      err_q            <= 1'b0;
      f3_q             <= 3'h0;
      off_q            <= 2'h0;
      mask_q           <= 8'h0;
      wide_q           <= 64'h0;
      lo_q             <= 32'h0;
      hi_q             <= 32'h0;
      data_addr        <= 32'h0;
      data_write       <= 32'h0;
      data_write_byte  <= 4'h0;
      data_read_valid  <= 1'b0;
      data_write_valid <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      lo_q             <= lo_n;
      hi_q             <= hi_n;
      data_addr        <= addr_n;
      data_write       <= wd_n;
      data_write_byte  <= be_n;
      data_read_valid  <= rd_n;
      data_write_valid <= wr_n;
      if (latch) begin
        st_q   <= req_is_store;
        err_q  <= !legal(req_is_store, req_funct3);
        f3_q   <= req_funct3;
        off_q  <= req_addr[1:0];
        mask_q <= mask_in;
        wide_q <= wide_in;
      end
    end
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit in the MEM stage of the pipelined RISC-V core; the initiator side of the byte-addressed data-memory interface.
- Accepts one load/store per handshake from the pipeline and derives word address, byte lanes and lane-aligned write data.
- Splits word-crossing misaligned accesses into two word accesses, then merges and sign/zero-extends load data.
- Returns one response per request.

Parameters:
MEM_LATENCY, 1, cycles each memory access is held before read data is captured (>=1)

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
req_valid  in  1  pipeline request valid
req_ready  out  1  LSU can accept (high only in IDLE, low while reset)
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  illegal funct3
data_addr  out  32  word-aligned memory address (low 2 bits 0)
data_write  out  32  lane-aligned write data
data_write_byte  out  4  byte-lane write enables
data_read_valid  out  1  read strobe
data_write_valid  out  1  write strobe
data_read  in  32  memory read word, combinational from data_addr

Behaviour:
- Reset: state IDLE; all outputs 0 (req_ready=0 while reset high, 1 on first cycle after). Reset mid-access aborts: strobes low next cycle, no resp_valid, latched request discarded.
- Memory-side outputs are registered; never read and write strobes together.
- Size N: funct3[1:0]=00->1, 01->2, 10->4. Legal loads 000,001,010,100,101; legal stores 000,001,010. Anything else -> error.
- off=addr[1:0]; mask8=((1<<N)-1)<<off; wide=req_wdata<<(8*off) (64-bit). split = mask8[7:4]!=0.
- FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
- IDLE: on req_valid&&req_ready latch request; illegal -> RESP with resp_err=1, no memory strobe; else ACC0.
- ACC0: data_addr={addr[31:2],2'b00}. Store: write_byte=mask8[3:0], write=wide[31:0], write_valid=1. Load: read_valid=1. Held MEM_LATENCY cycles; last cycle captures data_read into lo. Then ACC1 if split, else RESP.
- ACC1: data_addr=word0+4. Store: mask8[7:4], wide[63:32]. Load: captures hi. Held MEM_LATENCY cycles.
- Store lane with enable 0 drives 0 on data_write.
- RESP: resp_valid=1 one cycle. Load result = ({hi,lo}>>8*off) truncated to N bytes; sign-extended for 000/001, zero-extended for 100/101. hi=0 when not split.
- Latency accept->resp_valid: MEM_LATENCY+1 aligned; 2*MEM_LATENCY+1 split; 1 for error.
- req_ready low from accept through RESP; next accept earliest the cycle after RESP.
- Address wrap: word0+4 wraps modulo 2^32 (0xFFFFFFFF split -> ACC1 addr 0x00000000).

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE, ACC0, ACC1, RESP.
  - function size_of(funct3).
- One sub-module lsu_align, combinational:
  - store path: off, N -> 8-bit mask, 64-bit shifted data.
  - load path: {hi,lo}, off, funct3 -> extended 32-bit result.
- FSM and registers live in the top.

Test Plan:
- SW 0x12345678 @0x10, then LW @0x10 (L=1) -> write_byte=1111, data_addr=0x10; load resp_rdata=0x12345678, resp_valid 2 cycles after accept.
- SB 0xAB @0x13 -> write_byte=1000, data_write=0xAB000000. LB @0x13 -> 0xFFFFFFAB; LBU @0x13 -> 0x000000AB.
- SW 0xA1B2C3D4 @0x21:
  - ACC0: addr 0x20, bytes 1110, data 0xB2C3D400.
  - ACC1: addr 0x24, bytes 0001, data 0x000000A1.
  - LW @0x21 -> 0xA1B2C3D4, resp 3 cycles after accept.
- After previous: LH @0x23 -> 0xFFFFA1B2; LHU @0x23 -> 0x0000A1B2. Repeat with MEM_LATENCY=3 -> resp 7 cycles after accept.
- Load funct3=011 or store funct3=100 -> resp_err=1, resp_rdata=0 one cycle after accept; data_read_valid/data_write_valid never asserted.
- Reset asserted during ACC1 of split store:
  - all strobes 0 the next cycle; no resp_valid.
  - req_ready=1 the cycle after reset deasserts.
  - a new LW completes normally.
